// File: rtl/phy_pkg.sv
// Shared PHY definitions: the idle/alignment character and the link state
// encoding, reused by the transmitter, the receiver and the link FSM.
package phy_pkg;

  localparam logic [7:0] COM_CHAR = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

endpackage : phy_pkg

// File: rtl/serie_paralelo.sv
// Serial-to-parallel receiver: deserializes the MSB-first bit stream on clk_8f,
// aligns on COM characters and presents bytes with a data-valid flag.
module serie_paralelo
  import phy_pkg::*;
#(
  parameter logic [3:0] BC_COUNT = 4'd4
) (
  input  logic       clk_8f,
  input  logic       reset,
  input  logic       data_inS,
  output logic [7:0] data_outP,
  output logic       valid_out,
  output logic       byte_strobe,
  output logic       active
);

  // Only the seven most recent bits are stored; the eighth is the live input.
  logic [6:0] sr_q, sr_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] bc_cnt_q, bc_cnt_d;
  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       strobe_q, strobe_d;
  logic       active_q;
  logic [7:0] win_s;
  logic       byte_done_s;

  assign win_s       = {sr_q, data_inS};
  assign byte_done_s = (bit_cnt_q == 3'd7);

  // Next-state logic: shifting, bit/COM counting, alignment FSM and byte capture.
  always_comb begin
    sr_d      = win_s[6:0];
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    state_d   = state_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    case (state_q)
      SEARCH: begin
        if (win_s == COM_CHAR) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          state_d   = LOCKING;
        end else begin
          state_d = SEARCH;
        end
      end
      LOCKING: begin
        if (byte_done_s && (win_s == COM_CHAR)) begin
          bc_cnt_d = bc_cnt_q + 4'd1;
          if ((bc_cnt_q + 4'd1) == BC_COUNT) begin
            state_d = ACTIVE;
          end else begin
            state_d = LOCKING;
          end
        end else if (byte_done_s) begin
          bc_cnt_d = 4'd0;
          state_d  = SEARCH;
        end else begin
          state_d = LOCKING;
        end
      end
      ACTIVE: begin
        // Alignment is frozen here; only reset leaves this state.
        if (byte_done_s) begin
          data_d   = win_s;
          valid_d  = (win_s != COM_CHAR);
          strobe_d = 1'b1;
        end else begin
          strobe_d = 1'b0;
        end
      end
      default: begin
        state_d  = SEARCH;
        bc_cnt_d = 4'd0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_8f) begin
    if (!reset) begin
      sr_q      <= 7'd0;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= 4'd0;
      state_q   <= SEARCH;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      state_q   <= state_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= (state_d == ACTIVE);
    end
  end

  assign data_outP   = data_q;
  assign valid_out   = valid_q;
  assign byte_strobe = strobe_q;
  assign active      = active_q;

endmodule : serie_paralelo

// File: tb/tb_serie_paralelo.sv
// Directed self-checking bench for serie_paralelo: reset, lock, payload,
// failed lock, cross-boundary false pattern and reset during ACTIVE.
module tb_serie_paralelo;

  logic       clk_8f = 1'b0;
  logic       reset = 1'b0;
  logic       data_inS = 1'b0;
  logic [7:0] data_outP;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  int n_total = 0;
  int n_pass  = 0;

  serie_paralelo dut (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .data_inS   (data_inS),
    .data_outP  (data_outP),
    .valid_out  (valid_out),
    .byte_strobe(byte_strobe),
    .active     (active)
  );

  always #5 clk_8f = ~clk_8f;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one bit away from the active edge, then sample 1 time unit after it.
  task automatic send_bit(input logic b);
    @(negedge clk_8f);
    data_inS = b;
    @(posedge clk_8f);
    #1;
  endtask

  // Send a byte MSB-first; no strobe may appear before its last bit.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      send_bit(b[i]);
      if (i != 0) chk("strobe_mid_byte", {7'd0, byte_strobe}, 8'd0);
    end
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b0;
    for (int i = 0; i < n; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      chk("strobe_in_reset", {7'd0, byte_strobe}, 8'd0);
    end
    @(negedge clk_8f);
    reset = 1'b1;
  endtask

  // Four COM bytes from SEARCH: active rises exactly on the fourth, with no strobe.
  task automatic lock_seq(input string tag);
    for (int k = 1; k <= 4; k++) begin
      send_byte(8'hBC);
      chk({tag, "_active"}, {7'd0, active}, (k == 4) ? 8'd1 : 8'd0);
      chk({tag, "_strobe"}, {7'd0, byte_strobe}, 8'd0);
    end
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] d, input logic v);
    chk({tag, "_strobe"}, {7'd0, byte_strobe}, 8'd1);
    chk({tag, "_data"}, data_outP, d);
    chk({tag, "_valid"}, {7'd0, valid_out}, {7'd0, v});
  endtask

  initial begin
    // Reset with random serial activity.
    hold_reset(10);
    chk("rst_data", data_outP, 8'h00);
    chk("rst_valid", {7'd0, valid_out}, 8'd0);
    chk("rst_active", {7'd0, active}, 8'd0);

    // Lock after three random lead-in bits.
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    chk("pre_lock_active", {7'd0, active}, 8'd0);
    lock_seq("lock");

    // Payload, COM idle, payload: strobes on each LSB edge, 8 edges apart.
    send_byte(8'h5A);
    expect_byte("d5A", 8'h5A, 1'b1);
    send_byte(8'hBC);
    expect_byte("dBC", 8'hBC, 1'b0);
    send_byte(8'hFF);
    expect_byte("dFF", 8'hFF, 1'b1);
    send_bit(1'b0);
    chk("hold_data", data_outP, 8'hFF);
    chk("hold_strobe", {7'd0, byte_strobe}, 8'd0);
    for (int i = 6; i >= 0; i--) send_bit(1'b0);
    expect_byte("d00", 8'h00, 1'b1);

    // Cross-boundary 0xBC must not disturb alignment.
    send_byte(8'h0B);
    expect_byte("f0B", 8'h0B, 1'b1);
    send_byte(8'hC0);
    expect_byte("fC0", 8'hC0, 1'b1);
    chk("false_active", {7'd0, active}, 8'd1);

    // Reset while bit 3 of a payload byte is being sampled.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk_8f);
    reset = 1'b0;
    data_inS = 1'b0;
    @(posedge clk_8f);
    #1;
    chk("midrst_data", data_outP, 8'h00);
    chk("midrst_valid", {7'd0, valid_out}, 8'd0);
    chk("midrst_strobe", {7'd0, byte_strobe}, 8'd0);
    chk("midrst_active", {7'd0, active}, 8'd0);
    @(negedge clk_8f);
    reset = 1'b1;
    lock_seq("relock");

    // Failed lock returns to SEARCH, then a clean run locks.
    hold_reset(2);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h12);
    chk("fail_active", {7'd0, active}, 8'd0);
    chk("fail_strobe", {7'd0, byte_strobe}, 8'd0);
    lock_seq("fail_relock");
    send_byte(8'hA5);
    expect_byte("dA5", 8'hA5, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule : tb_serie_paralelo
